// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory signals of the MEM-stage load/store controller.
// slave: the controller's view. master: the pipeline-plus-memory view.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] RWAddress;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata, DataOut,
    output req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, RWAddress, DataIn
  );

  modport master (
    output req_valid, req_load, req_store, req_size, req_signed, req_addr, req_wdata, DataOut,
    input  req_ready, resp_valid, resp_rdata, resp_err, MemRead, MemWrite, RWAddress, DataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store initiator: aligned byte/half/word accesses, sub-word stores by read-modify-write.
// Define MEM_ACCESS_STATS_EN to add saturating load/store/error counters (stat_loads/stat_stores/stat_errs).
module mem_access_ctrl #(
  parameter int WORDS = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  localparam logic [31:0] ADDR_LIMIT = 32'(WORDS * 4);

  typedef enum logic [2:0] {S_IDLE, S_LD, S_RMW_RD, S_RMW_WR, S_WR, S_ERR, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        load_q, load_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  function automatic logic access_err(input logic ld, input logic st, input logic [1:0] size,
                                      input logic [31:0] addr);
    access_err = (ld == st) || (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00) ||
                 (addr >= ADDR_LIMIT);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   extend_load = {{24{sgn & b[7]}}, b};
      2'b01:   extend_load = {{16{sgn & h[15]}}, h};
      default: extend_load = w;
    endcase
  endfunction

  // Only the addressed lanes of the old word are replaced.
  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    merge_store = w;
    if (size == 2'b00) begin
      merge_store[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      merge_store[31:16] = wd[15:0];
    end else begin
      merge_store[15:0] = wd[15:0];
    end
  endfunction

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    word_d         = word_q;
    size_d         = size_q;
    signed_d       = signed_q;
    load_d         = load_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RWAddress  = 32'h0;
    bus.DataIn     = 32'h0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          load_d   = bus.req_load;
          if (access_err(bus.req_load, bus.req_store, bus.req_size, bus.req_addr)) begin
            state_d = S_ERR;
          end else if (bus.req_load) begin
            state_d = S_LD;
          end else if (bus.req_size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LD: begin
        bus.MemRead   = 1'b1;
        bus.RWAddress = {addr_q[31:2], 2'b00};
        rdata_d       = extend_load(bus.DataOut, size_q, addr_q[1:0], signed_q);
        err_d         = 1'b0;
        state_d       = S_RESP;
      end
      S_RMW_RD: begin
        bus.MemRead   = 1'b1;
        bus.RWAddress = {addr_q[31:2], 2'b00};
        word_d        = bus.DataOut;
        state_d       = S_RMW_WR;
      end
      S_RMW_WR: begin
        bus.MemWrite  = 1'b1;
        bus.RWAddress = {addr_q[31:2], 2'b00};
        bus.DataIn    = merge_store(word_q, wdata_q, size_q, addr_q[1:0]);
        rdata_d       = 32'h0;
        err_d         = 1'b0;
        state_d       = S_RESP;
      end
      S_WR: begin
        bus.MemWrite  = 1'b1;
        bus.RWAddress = {addr_q[31:2], 2'b00};
        bus.DataIn    = wdata_q;
        rdata_d       = 32'h0;
        err_d         = 1'b0;
        state_d       = S_RESP;
      end
      S_ERR: begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields and the RMW capture word are only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    word_q   <= word_d;
    size_q   <= size_d;
    signed_q <= signed_d;
    load_q   <= load_d;
  end

`ifdef MEM_ACCESS_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= 16'h0;
      stat_stores <= 16'h0;
      stat_errs   <= 16'h0;
    end else if (state_q == S_RESP) begin
      if (err_q) begin
        stat_errs <= sat_inc(stat_errs);
      end else if (load_q) begin
        stat_loads <= sat_inc(stat_loads);
      end else begin
        stat_stores <= sat_inc(stat_stores);
      end
    end
  end
`endif

endmodule
